// File: rtl/read_enable_data_packer.sv
// Packs RATIO consecutive upstream FIFO words into one wide word behind a FIFO-style read interface.
// Optional partial-word flush is enabled by defining READ_ENABLE_DATA_PACKER_FLUSH_EN.
module read_enable_data_packer #(
  parameter int INPUT_WIDTH  = 8,
  parameter int RATIO        = 4,
  parameter int OUTPUT_WIDTH = INPUT_WIDTH * RATIO
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       upstream_read_enable,
  input  logic [INPUT_WIDTH-1:0]     upstream_data,
  input  logic                       upstream_empty,
  input  logic                       downstream_read_enable,
  output logic [OUTPUT_WIDTH-1:0]    downstream_data,
  output logic                       downstream_empty
`ifdef READ_ENABLE_DATA_PACKER_FLUSH_EN
  ,
  input  logic                       flush,
  output logic [$clog2(RATIO+1)-1:0] downstream_count
`endif
);

  localparam int CW = $clog2(RATIO + 1);
  localparam logic [CW-1:0] FULL = CW'(RATIO);
  localparam logic [CW-1:0] ONE  = CW'(1'b1);

  logic [INPUT_WIDTH-1:0] r_lane [RATIO];
  logic [CW-1:0]          r_count;
  logic                   w_held;
  logic                   w_full;
  logic                   w_valid;
  logic                   w_pop_up;
  logic                   w_pop_down;
  logic [CW-1:0]          w_wr_idx;
  logic [CW-1:0]          w_cnt_after;

  assign w_full     = (r_count == FULL);
  assign w_valid    = w_full | w_held;
  assign w_pop_down = downstream_read_enable & w_valid;
  assign w_pop_up   = ~reset & ~upstream_empty & ~w_held & (~w_full | downstream_read_enable);
  assign upstream_read_enable = w_pop_up;
  assign downstream_empty     = ~w_valid;
  // A simultaneous pop restarts filling at lane 0 so there is no bubble between packed words.
  assign w_wr_idx = w_pop_down ? {CW{1'b0}} : r_count;

  // Fill count after this cycle's upstream and downstream pops.
  always_comb begin
    w_cnt_after = r_count;
    if (w_pop_up) begin
      w_cnt_after = w_pop_down ? ONE : (r_count + ONE);
    end else if (w_pop_down) begin
      w_cnt_after = {CW{1'b0}};
    end else begin
      w_cnt_after = r_count;
    end
  end

  // Lane storage and fill counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= {CW{1'b0}};
      for (int i = 0; i < RATIO; i++) begin
        r_lane[i] <= {INPUT_WIDTH{1'b0}};
      end
    end else begin
      r_count <= w_cnt_after;
      for (int i = 0; i < RATIO; i++) begin
        if (w_pop_up && (w_wr_idx == CW'(i))) begin
          r_lane[i] <= upstream_data;
        end else begin
          r_lane[i] <= r_lane[i];
        end
      end
    end
  end

  // Packed output; lanes beyond the fill level are zeroed only for a flushed partial word.
  always_comb begin
    downstream_data = {OUTPUT_WIDTH{1'b0}};
    for (int i = 0; i < RATIO; i++) begin
      downstream_data[i*INPUT_WIDTH +: INPUT_WIDTH] =
        (!w_held || (CW'(i) < r_count)) ? r_lane[i] : {INPUT_WIDTH{1'b0}};
    end
  end

`ifdef READ_ENABLE_DATA_PACKER_FLUSH_EN
  logic r_held;

  // Partial-word hold flag; flush uses the count after any same-cycle upstream pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_held <= 1'b0;
    end else begin
      r_held <= (r_held & ~w_pop_down) |
                (flush & (w_cnt_after != {CW{1'b0}}) & (w_cnt_after != FULL));
    end
  end

  assign w_held           = r_held;
  assign downstream_count = w_valid ? r_count : {CW{1'b0}};
`else
  assign w_held = 1'b0;
`endif

endmodule
